// File: rtl/arbitro_memoria_dados_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_memoria_dados_pkg
// Shared definitions for the data-memory arbiter:
//   - state_t   : FSM encoding (IDLE / ACCESS / RESP)
//   - PORT_CPU  : index of port 0 (nRisc core)
//   - PORT_HOST : index of port 1 (host / loader)
//   - other_port: returns the index of the opposite requester
// ---------------------------------------------------------------------------
package arbitro_memoria_dados_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/arbitro_memoria_dados_rr.sv
// ---------------------------------------------------------------------------
// arbitro_rr
// Two-way round-robin pick, purely combinational.
// Ports:
//   req0, req1 : in  request lines (already masked by the caller)
//   last       : in  index of the port served most recently
//   valid      : out at least one request present
//   winner     : out index of the granted port (meaningful when valid)
// A lone requester always wins; on a tie the port not served last wins.
// ---------------------------------------------------------------------------
module arbitro_rr
    import arbitro_memoria_dados_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = other_port(last);
        end else if (req1) begin
            winner = PORT_HOST;
        end
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// ---------------------------------------------------------------------------
// arbitro_memoria_dados
// Arbitrates two requesters (port 0 = nRisc core, port 1 = host/loader)
// onto a single synchronous data memory (MemoriaDados).
//
// Ports:
//   Clock, Reset               : single clock, async active-low reset
//   req0/we0/addr0/wdata0      : port 0 request (held until ack0)
//   ack0, rdata0               : port 0 one-cycle completion pulse, read data
//   req1/we1/addr1/wdata1      : port 1 request (held until ack1)
//   ack1, rdata1               : port 1 completion pulse, read data
//   Endereco, DadoEscr         : memory address / write data (last latched)
//   MemWrite, MemRead          : memory strobes, only active in ACCESS
//   DadoLido                   : memory read data, valid in RESP
//   cpu_stall                  : port 0 waiting (req0 without ack0)
//   busy                       : an access is in flight (ACCESS or RESP)
//   owner                      : index of the port owning the current access
//   gnt_cnt0, gnt_cnt1         : wrapping 8-bit ack counters per port
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no access in flight; latch a winner on any req
// ACCESS | strobe memory with the latched request
// RESP   | ack the owner, capture read data, chain the other port
// ---------------------------------------------------------------------------
module arbitro_memoria_dados
    import arbitro_memoria_dados_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] Endereco,
    output logic [DATA_W-1:0] DadoEscr,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] DadoLido,

    output logic              cpu_stall,
    output logic              busy,
    output logic              owner,
    output logic [7:0]        gnt_cnt0,
    output logic [7:0]        gnt_cnt1
);

    state_t              state_q,  state_d;
    logic                owner_q,  owner_d;
    logic                last_q,   last_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [7:0]          cnt0_q,   cnt0_d;
    logic [7:0]          cnt1_q,   cnt1_d;

    logic                rr_req0;
    logic                rr_req1;
    logic                rr_last;
    logic                rr_valid;
    logic                rr_winner;

    // Only IDLE and RESP may latch a new request. In RESP the owner has
    // just been served, so only the other port competes; the pick then
    // degenerates to the single remaining requester.
    always_comb begin
        rr_req0 = 1'b0;
        rr_req1 = 1'b0;
        rr_last = last_q;
        case (state_q)
            IDLE: begin
                rr_req0 = req0;
                rr_req1 = req1;
            end
            RESP: begin
                rr_req0 = req0 & (owner_q != PORT_CPU);
                rr_req1 = req1 & (owner_q != PORT_HOST);
                rr_last = owner_q;
            end
            default: begin
                rr_req0 = 1'b0;
                rr_req1 = 1'b0;
            end
        endcase
    end

    arbitro_rr u_rr (
        .req0   (rr_req0),
        .req1   (rr_req1),
        .last   (rr_last),
        .valid  (rr_valid),
        .winner (rr_winner)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                state_d = RESP;
            end

            RESP: begin
                last_d = owner_q;
                if (owner_q == PORT_CPU) begin
                    cnt0_d = cnt0_q + 8'd1;
                    if (!we_q) begin
                        rdata0_d = DadoLido;
                    end
                end else begin
                    cnt1_d = cnt1_q + 8'd1;
                    if (!we_q) begin
                        rdata1_d = DadoLido;
                    end
                end
                state_d = rr_valid ? ACCESS : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared latch path for both IDLE and back-to-back RESP grants.
        if ((state_q == IDLE || state_q == RESP) && rr_valid) begin
            owner_d = rr_winner;
            if (rr_winner == PORT_HOST) begin
                we_d    = we1;
                addr_d  = addr1;
                wdata_d = wdata1;
            end else begin
                we_d    = we0;
                addr_d  = addr0;
                wdata_d = wdata0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            owner_q  <= PORT_CPU;
            last_q   <= PORT_HOST;   // port 0 wins the first tie
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt0_q   <= 8'd0;
            cnt1_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // All outputs decode from registered state, so the async reset clears
    // strobes and acks without waiting for a clock edge.
    assign ack0      = (state_q == RESP) && (owner_q == PORT_CPU);
    assign ack1      = (state_q == RESP) && (owner_q == PORT_HOST);
    assign MemWrite  = (state_q == ACCESS) &&  we_q;
    assign MemRead   = (state_q == ACCESS) && !we_q;
    assign Endereco  = addr_q;
    assign DadoEscr  = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign cpu_stall = req0 & ~ack0;
    assign busy      = (state_q == ACCESS) || (state_q == RESP);
    assign owner     = owner_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
module tb_arbitro_memoria_dados;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } tx_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] Endereco, DadoEscr, DadoLido;
    logic       MemWrite, MemRead;
    logic       cpu_stall, busy, owner;
    logic [7:0] gnt_cnt0, gnt_cnt1;

    arbitro_memoria_dados #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .Endereco  (Endereco),
        .DadoEscr  (DadoEscr),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .DadoLido  (DadoLido),
        .cpu_stall (cpu_stall),
        .busy      (busy),
        .owner     (owner),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    always #5 Clock = ~Clock;

    // Synchronous data memory seen by the arbiter.
    logic [7:0] ram [256];
    always @(posedge Clock) begin
        if (MemWrite) ram[Endereco] <= DadoEscr;
        if (MemRead)  DadoLido      <= ram[Endereco];
    end

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference: each requester owns a FIFO of pending
    // accesses; the arbiter completes one access two edges after granting.
    tx_t        q0[$];
    tx_t        q1[$];
    logic [7:0] ref_mem [256];
    logic [7:0] m_rd0, m_rd1, m_cnt0, m_cnt1;
    logic       m_busy, m_port, m_owner, m_last;
    int         m_done;
    tx_t        m_tx;
    int         ecount;
    int         ack0_at, ack1_at;
    int         gseq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_busy  = 1'b0;
        m_port  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_rd0   = 8'h00;
        m_rd1   = 8'h00;
        m_cnt0  = 8'h00;
        m_cnt1  = 8'h00;
        m_done  = -10;
    endtask

    task automatic drive_inputs();
        req0 = (q0.size() != 0);
        req1 = (q1.size() != 0);
        if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
        if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_memwrite"}, 32'(MemWrite), 32'd0);
        check({pfx, "_memread"},  32'(MemRead),  32'd0);
        check({pfx, "_ack0"},     32'(ack0),     32'd0);
        check({pfx, "_ack1"},     32'(ack1),     32'd0);
        check({pfx, "_busy"},     32'(busy),     32'd0);
        check({pfx, "_owner"},    32'(owner),    32'd0);
        check({pfx, "_rdata0"},   32'(rdata0),   32'd0);
        check({pfx, "_rdata1"},   32'(rdata1),   32'd0);
        check({pfx, "_endereco"}, 32'(Endereco), 32'd0);
        check({pfx, "_dadoescr"}, 32'(DadoEscr), 32'd0);
        check({pfx, "_gnt0"},     32'(gnt_cnt0), 32'd0);
        check({pfx, "_gnt1"},     32'(gnt_cnt1), 32'd0);
    endtask

    // One clock cycle: check the current cycle against the reference, then
    // advance the reference to the coming edge and drive the requesters.
    task automatic step();
        logic e_ack0, e_ack1, e_acc;
        int   excl;
        @(negedge Clock);
        e_ack0 = m_busy && (m_done == ecount + 1) && (m_port == 1'b0);
        e_ack1 = m_busy && (m_done == ecount + 1) && (m_port == 1'b1);
        e_acc  = m_busy && (m_done == ecount + 2);
        check("ack0",     32'(ack0),     32'(e_ack0));
        check("ack1",     32'(ack1),     32'(e_ack1));
        check("busy",     32'(busy),     32'(m_busy));
        check("memwrite", 32'(MemWrite), 32'(e_acc && m_tx.we));
        check("memread",  32'(MemRead),  32'(e_acc && !m_tx.we));
        if (e_acc) begin
            check("endereco", 32'(Endereco), 32'(m_tx.addr));
            if (m_tx.we) check("dadoescr", 32'(DadoEscr), 32'(m_tx.data));
        end
        check("owner",  32'(owner),    32'(m_owner));
        check("rdata0", 32'(rdata0),   32'(m_rd0));
        check("rdata1", 32'(rdata1),   32'(m_rd1));
        check("gnt0",   32'(gnt_cnt0), 32'(m_cnt0));
        check("gnt1",   32'(gnt_cnt1), 32'(m_cnt1));
        if (ack0 === 1'b1) begin ack0_at = ecount; gseq.push_back(0); end
        if (ack1 === 1'b1) begin ack1_at = ecount; gseq.push_back(1); end

        excl = 2;
        if (m_busy && (m_done == ecount + 1)) begin
            if (m_tx.we)          ref_mem[m_tx.addr] = m_tx.data;
            else if (m_port == 0) m_rd0 = ref_mem[m_tx.addr];
            else                  m_rd1 = ref_mem[m_tx.addr];
            if (m_port == 0) begin m_cnt0 = m_cnt0 + 8'd1; void'(q0.pop_front()); end
            else             begin m_cnt1 = m_cnt1 + 8'd1; void'(q1.pop_front()); end
            m_last = m_port;
            m_busy = 1'b0;
            excl   = int'(m_port);
        end
        if (!m_busy) begin
            logic c0, c1, p;
            c0 = (q0.size() != 0) && (excl != 0);
            c1 = (q1.size() != 0) && (excl != 1);
            if (c0 || c1) begin
                p       = (c0 && c1) ? ~m_last : c1;
                m_busy  = 1'b1;
                m_port  = p;
                m_owner = p;
                m_tx    = p ? q1[0] : q0[0];
                m_done  = ecount + 3;
            end
        end
        drive_inputs();
        #1;
        check("cpu_stall", 32'(cpu_stall), 32'(req0 && !e_ack0));
        @(posedge Clock);
        ecount++;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy) && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n >= max_cycles), 32'd0);
        repeat (2) step();
    endtask

    task automatic do_reset(input string pfx);
        Reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        #1;
        reset_checks(pfx);
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        ecount++;
    endtask

    function automatic tx_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
        tx_t t;
        t.we = we; t.addr = a; t.data = d;
        return t;
    endfunction

    function automatic tx_t rnd_tx();
        return mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    endfunction

    initial begin
        ecount  = 0;
        ack0_at = -100;
        ack1_at = -100;
        Reset   = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        model_reset();
        #3;
        reset_checks("por");
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        ecount++;

        // Preload every address that is read later so no read sees uninitialised memory.
        for (int a = 0; a < 16; a++) q1.push_back(mk(1'b1, 8'(a), 8'($urandom)));
        q1.push_back(mk(1'b1, 8'hF0, 8'h3C));
        drain(200);

        // Port 0 write then read-back.
        do_reset("rst_a");
        q0.push_back(mk(1'b1, 8'h10, 8'hA5));
        q0.push_back(mk(1'b0, 8'h10, 8'h00));
        drain(50);
        check("wr_rd_rdata0", 32'(rdata0),   32'h0000_00A5);
        check("wr_rd_gnt0",   32'(gnt_cnt0), 32'd2);

        // Simultaneous first requests: port 0 first, port 1 chained.
        do_reset("rst_b");
        q0.push_back(mk(1'b0, 8'h01, 8'h00));
        q1.push_back(mk(1'b0, 8'h02, 8'h00));
        drain(50);
        check("tie_ack_gap", 32'(ack1_at - ack0_at), 32'd2);

        // Continuous demand from both ports: grants alternate.
        do_reset("rst_c");
        gseq.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rnd_tx());
            q1.push_back(rnd_tx());
        end
        drain(100);
        check("alt_len", 32'(gseq.size()), 32'd8);
        for (int i = 0; i < gseq.size() && i < 8; i++)
            check("alt_order", 32'(gseq[i]), 32'(i % 2));
        check("alt_gnt0", 32'(gnt_cnt0), 32'd4);
        check("alt_gnt1", 32'(gnt_cnt1), 32'd4);

        // Reset during the ACCESS cycle of a port 1 write to 0xF0.
        do_reset("rst_d");
        q1.push_back(mk(1'b1, 8'hF0, 8'h99));
        begin
            int n;
            n = 0;
            while (!(m_busy && m_port == 1'b1 && m_done == ecount + 2) && n < 20) begin
                step();
                n++;
            end
            check("abort_reach_access", 32'(n >= 20), 32'd0);
        end
        #2;
        check("abort_memwrite_pre", 32'(MemWrite), 32'd1);
        do_reset("abort");
        repeat (5) step();
        q0.push_back(mk(1'b0, 8'hF0, 8'h00));
        drain(50);
        check("abort_not_written", 32'(rdata0), 32'h0000_003C);

        // 256 port 1 accesses wrap its counter; rdata0 must not move.
        do_reset("rst_e");
        q0.push_back(mk(1'b1, 8'h33, 8'h5C));
        q0.push_back(mk(1'b0, 8'h33, 8'h00));
        drain(50);
        for (int i = 0; i < 256; i++) q1.push_back(rnd_tx());
        drain(1200);
        check("wrap_gnt1",   32'(gnt_cnt1), 32'd0);
        check("wrap_gnt0",   32'(gnt_cnt0), 32'd2);
        check("wrap_rdata0", 32'(rdata0),   32'h0000_005C);

        // Random mixed traffic from both ports.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) q0.push_back(rnd_tx());
                else                           q1.push_back(rnd_tx());
            end
            step();
        end
        drain(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_dados.md
ARBITRO_MEMORIA_DADOS -- requirements
Module: arbitro_memoria_dados

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, data-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data word width.
REQ-003 The block SHALL have port Clock  in  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0/we0  in  1/1, addr0  in  ADDR_W, wdata0  in  DATA_W  for port 0, the nRisc core.
REQ-006 The block SHALL have ports ack0  out  1  and rdata0  out  DATA_W  for port 0 completion.
REQ-007 The block SHALL have ports req1, we1, addr1, wdata1, ack1, rdata1, same widths as port 0, for port 1, the host/loader.
REQ-008 The block SHALL have ports Endereco  out  ADDR_W, DadoEscr  out  DATA_W, MemWrite  out  1, MemRead  out  1, DadoLido  in  DATA_W  to MemoriaDados.
REQ-009 The block SHALL have ports cpu_stall  out  1, busy  out  1, owner  out  1, gnt_cnt0/gnt_cnt1  out  8/8.

Function
REQ-010 Requester handshake: req held high with addr/we/wdata stable until ack seen; ack is a single-cycle pulse; requester drops or re-issues req the cycle after ack.
REQ-011 FSM states: IDLE, ACCESS, RESP; one access takes exactly 2 cycles (ACCESS, RESP) after the winner is latched.
REQ-012 IDLE: if any req high, latch winner index into owner, latch its addr/we/wdata, next state ACCESS; else stay IDLE.
REQ-013 Tie (req0 and req1 both high at the latching edge): grant the port not served last (round-robin); single requester always wins.
REQ-014 ACCESS: drive Endereco/DadoEscr from latched request; MemWrite = we, MemRead = ~we; next state RESP.
REQ-015 Outside ACCESS, MemWrite and MemRead SHALL be 0; Endereco/DadoEscr hold the last latched values.
REQ-016 RESP: assert ack of owner for one cycle; for reads, capture DadoLido into the owner's rdata register; for writes, the owner's rdata is unchanged.
REQ-017 RESP: if the non-owner's req is high, latch it and go to ACCESS directly (back-to-back, no IDLE bubble); otherwise go IDLE.
REQ-018 The owner's own req in the RESP cycle SHALL be ignored (already served).
REQ-019 The last-served flag SHALL update on each RESP to owner.
REQ-020 cpu_stall = req0 AND NOT ack0 (combinational).
REQ-021 busy = 1 in ACCESS or RESP.
REQ-022 gnt_cnt0/gnt_cnt1 SHALL increment on each ack of the port, wrapping 255 -> 0.
REQ-023 Port 0 and port 1 rdata registers SHALL be independent; a port 1 read SHALL never alter rdata0.

Reset
REQ-024 Reset low SHALL immediately force: state IDLE, MemWrite=0, MemRead=0, ack0=ack1=0, rdata0=rdata1=0, Endereco=0, DadoEscr=0, owner=0, gnt_cnt0=gnt_cnt1=0, last-served flag = port 1 (so port 0 wins first tie).
REQ-025 Reset asserted mid-access SHALL abort with no ack; a write whose ACCESS edge already occurred remains committed in memory.
REQ-026 After Reset rises, first arbitration SHALL happen on the first rising edge with req high.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and port index constants PORT_CPU=0, PORT_HOST=1.
REQ-028 One sub-module arbitro_rr SHALL implement the 2-way round-robin pick (inputs req0, req1, last; outputs valid, winner), purely combinational.

Verification
REQ-029 Port 0 write addr 8'h10 data 8'hA5, then read 8'h10 -> MemWrite pulse in ACCESS, ack0 two cycles after latch each time, rdata0=8'hA5, gnt_cnt0=2.
REQ-030 req0 and req1 rise together after reset (reads of 8'h01, 8'h02) -> port 0 served first, port 1 back-to-back with no IDLE cycle, ack1 exactly 2 cycles after ack0.
REQ-031 Both ports request continuously for 8 accesses -> grants alternate 0,1,0,1,...; gnt_cnt0=gnt_cnt1=4; cpu_stall high whenever req0 pending without ack0.
REQ-032 Reset pulled low during ACCESS of a port 1 write -> MemWrite/ack1 drop immediately, state IDLE, counters 0, no ack issued after release until new req.
REQ-033 256 port 1 acks -> gnt_cnt1 wraps to 8'h00; rdata0 unchanged throughout port 1 reads.
